pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 24 ++
 rtl/pc_next_sel.sv | 53 +++++
 rtl/pc_gen.sv | 88 ++++++++
 tb/tb_pc_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
//------------------------------------------------------------------
// pc_gen_pkg: FSM states and step constants for pc_gen. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package pc_gen_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   localparam int STEP_FULL = 4;
   localparam int STEP_HALF = 2;

   // Bit 0 is never legal; bit 1 is legal only when 2-byte alignment is allowed.
   function automatic logic misaligned(input logic [1:0] low, input logic half_ok);
      return low[0] | (~half_ok & low[1]);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
//------------------------------------------------------------------
// pc_next_sel: next-PC priority select, alignment check and adder. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module pc_next_sel
   import pc_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int C_EXT = 0
) (
   input  state_e            state,
   input  logic [XLEN-1:0]   pc,
   input  logic              pc_ready,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_target,
   input  logic              trap_valid,
   input  logic [XLEN-1:0]   trap_vector,
   input  logic              is_compressed,
   output logic [XLEN-1:0]   next_pc,
   output logic              misalign
);

   localparam logic c_half_ok = (C_EXT != 0);

   logic [XLEN-1:0] w_step;

   assign w_step = (c_half_ok && is_compressed) ? XLEN'(STEP_HALF) : XLEN'(STEP_FULL);

   // A rejected target leaves pc untouched; the sequential step is dropped too.
   always_comb begin
      next_pc  = pc;
      misalign = 1'b0;
      if (trap_valid) begin
         if (misaligned(trap_vector[1:0], c_half_ok)) begin
            misalign = 1'b1;
         end else begin
            next_pc = trap_vector;
         end
      end else if (redirect_valid && (state != BOOT)) begin
         if (misaligned(redirect_target[1:0], c_half_ok)) begin
            misalign = 1'b1;
         end else begin
            next_pc = redirect_target;
         end
      end else if ((state == RUN) && pc_ready) begin
         next_pc = pc + w_step;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
//------------------------------------------------------------------
// pc_gen: program counter generator with trap/redirect/halt control. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int              C_EXT     = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pc_ready,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_target,
   input  logic              trap_valid,
   input  logic [XLEN-1:0]   trap_vector,
   input  logic              halt_req,
   input  logic              resume,
   input  logic              is_compressed,
   output logic [XLEN-1:0]   pc,
   output logic              pc_valid,
   output logic              misalign_err,
   output logic              halted
);

   generate
      if ((RESET_VEC[0] == 1'b1) || ((C_EXT == 0) && (RESET_VEC[1] == 1'b1))) begin : g_bad_reset_vec
         $error("pc_gen: RESET_VEC is not aligned for the selected C_EXT");
      end
   endgenerate

   state_e          r_state;
   state_e          w_state_next;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_next;
   logic            r_misalign;
   logic            w_misalign;

   pc_next_sel #(
      .XLEN  (XLEN),
      .C_EXT (C_EXT)
   ) u_next_sel (
      .state           (r_state),
      .pc              (r_pc),
      .pc_ready        (pc_ready),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_valid      (trap_valid),
      .trap_vector     (trap_vector),
      .is_compressed   (is_compressed),
      .next_pc         (w_pc_next),
      .misalign        (w_misalign)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= BOOT;
         r_pc       <= RESET_VEC;
         r_misalign <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_misalign <= w_misalign;
      end
   end

   // A trap wakes HALT even when its vector is rejected.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         BOOT:    w_state_next = RUN;
         RUN:     if (halt_req) w_state_next = HALT;
         HALT:    if (resume || trap_valid) w_state_next = RUN;
         default: w_state_next = BOOT;
      endcase
   end

   assign pc           = r_pc;
   assign pc_valid     = (r_state == RUN);
   assign halted       = (r_state == HALT);
   assign misalign_err = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
//------------------------------------------------------------------
// tb_pc_gen: directed table, hand sequences and random run for pc_gen. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_pc_gen;

   localparam logic [31:0] RV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        trap_valid = 1'b0;
   logic [31:0] trap_vector = '0;
   logic        halt_req = 1'b0;
   logic        resume = 1'b0;
   logic        is_compressed = 1'b0;

   logic [31:0] pc_0, pc_1;
   logic        pc_valid_0, pc_valid_1;
   logic        misalign_err_0, misalign_err_1;
   logic        halted_0, halted_1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_gen #(.XLEN(32), .RESET_VEC(RV), .C_EXT(0)) dut_c0 (
      .clk(clk), .rst(rst), .pc_ready(pc_ready),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .trap_valid(trap_valid), .trap_vector(trap_vector),
      .halt_req(halt_req), .resume(resume), .is_compressed(is_compressed),
      .pc(pc_0), .pc_valid(pc_valid_0), .misalign_err(misalign_err_0), .halted(halted_0)
   );

   pc_gen #(.XLEN(32), .RESET_VEC(RV), .C_EXT(1)) dut_c1 (
      .clk(clk), .rst(rst), .pc_ready(pc_ready),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .trap_valid(trap_valid), .trap_vector(trap_vector),
      .halt_req(halt_req), .resume(resume), .is_compressed(is_compressed),
      .pc(pc_1), .pc_valid(pc_valid_1), .misalign_err(misalign_err_1), .halted(halted_1)
   );

   // Reference model, index 0 = C_EXT 0, index 1 = C_EXT 1. mode: 0 boot, 1 run, 2 halt.
   int          m_mode [2];
   logic [31:0] m_pc   [2];
   logic        m_err  [2];

   task automatic model_tick();
      for (int k = 0; k < 2; k++) begin
         longint unsigned npc   = m_pc[k];
         int              nmode = m_mode[k];
         bit              nerr  = 1'b0;
         int              align = (k == 1) ? 2 : 4;
         if (rst) begin
            npc   = RV;
            nmode = 0;
         end else begin
            if (trap_valid) begin
               if (trap_vector % align == 0) npc = trap_vector;
               else nerr = 1'b1;
            end else if (redirect_valid && m_mode[k] != 0) begin
               if (redirect_target % align == 0) npc = redirect_target;
               else nerr = 1'b1;
            end else if (m_mode[k] == 1 && pc_ready) begin
               npc = (longint'(m_pc[k]) + ((k == 1 && is_compressed) ? 2 : 4)) % 64'h1_0000_0000;
            end
            if (m_mode[k] == 0) nmode = 1;
            else if (m_mode[k] == 1 && halt_req) nmode = 2;
            else if (m_mode[k] == 2 && (resume || trap_valid)) nmode = 1;
         end
         m_pc[k]   = npc[31:0];
         m_mode[k] = nmode;
         m_err[k]  = nerr;
      end
   endtask

   task automatic tick();
      model_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_dut(input string name, input int k, input logic [31:0] epc,
                            input logic ev, input logic eh, input logic ee);
      logic [34:0] act, exp_v;
      if (k == 0) act = {pc_0, pc_valid_0, halted_0, misalign_err_0};
      else        act = {pc_1, pc_valid_1, halted_1, misalign_err_1};
      exp_v = {epc, ev, eh, ee};
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s c_ext=%0d: got pc=%h valid=%b halted=%b err=%b, want pc=%h valid=%b halted=%b err=%b",
                  name, k, act[34:3], act[2], act[1], act[0], epc, ev, eh, ee);
      end
   endtask

   task automatic check_model(input string name);
      for (int k = 0; k < 2; k++)
         check_dut(name, k, m_pc[k], m_mode[k] == 1, m_mode[k] == 2, m_err[k]);
   endtask

   task automatic set_in(input logic r, input logic rdy, input logic rv, input logic [31:0] rt,
                         input logic tv, input logic [31:0] tvec, input logic hr,
                         input logic res, input logic cmp);
      rst = r; pc_ready = rdy; redirect_valid = rv; redirect_target = rt;
      trap_valid = tv; trap_vector = tvec; halt_req = hr; resume = res; is_compressed = cmp;
   endtask

   typedef struct packed {
      logic        rst, rdy, rv;
      logic [31:0] rt;
      logic        tv;
      logic [31:0] tvec;
      logic        hr, res, cmp;
      logic [31:0] pc0, pc1;
      logic        v, h, e0, e1;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [31:0] rt,
                               input logic tv, input logic [31:0] tvec, input logic hr,
                               input logic res, input logic cmp, input logic [31:0] pc0,
                               input logic [31:0] pc1, input logic v, input logic h,
                               input logic e0, input logic e1);
      vec_t x;
      x.rst = r; x.rdy = rdy; x.rv = rv; x.rt = rt; x.tv = tv; x.tvec = tvec;
      x.hr = hr; x.res = res; x.cmp = cmp; x.pc0 = pc0; x.pc1 = pc1;
      x.v = v; x.h = h; x.e0 = e0; x.e1 = e1;
      return x;
   endfunction

   vec_t vecs[$];

   initial begin
      //             rst rdy rv rt            tv tvec          hr res cmp  pc0           pc1           v  h  e0 e1
      vecs.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0, 0, 32'h100,      32'h100,      0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0, 32'h100,      32'h100,      1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0, 32'h104,      32'h104,      1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0, 32'h108,      32'h108,      1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 1, 32'h10C,      32'h10A,      1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0, 32'h110,      32'h10E,      1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 32'h200,      0, 0,            0, 0, 0, 32'h200,      32'h200,      1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 1, 32'h204,      32'h202,      1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0, 32'h208,      32'h206,      1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'h400,      1, 32'h80,       0, 0, 0, 32'h80,       32'h80,       1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0, 0, 32'h80,       32'h80,       1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0, 0, 32'h80,       32'h80,       1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0, 32'h84,       32'h84,       1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 32'h302,      0, 0,            0, 0, 0, 32'h84,       32'h302,      1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0, 0, 32'h84,       32'h302,      1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'h301,      0, 0,            0, 0, 0, 32'h84,       32'h302,      1, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0, 0, 32'h84,       32'h302,      1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'h300,      0, 0,            0, 0, 0, 32'h300,      32'h300,      1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            1, 0, 0, 32'h304,      32'h304,      0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 1, 32'h500,      0, 0,            0, 0, 0, 32'h500,      32'h500,      0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            1, 0, 0, 32'h500,      32'h500,      0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 1, 0, 32'h500,      32'h500,      1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0, 32'h504,      32'h504,      1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 32'h600,      0, 0,            1, 0, 0, 32'h600,      32'h600,      0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,            1, 32'h81,       0, 0, 0, 32'h600,      32'h600,      1, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0, 0, 32'h600,      32'h600,      1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0,            0, 0,            1, 0, 0, 32'h600,      32'h600,      0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0,            1, 32'h40,       0, 0, 0, 32'h100,      32'h100,      0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0, 32'h100,      32'h100,      1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            1, 32'h802,      0, 0, 0, 32'h100,      32'h802,      1, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 1, 0, 32'h104,      32'h806,      1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0, 0, 32'h100,      32'h100,      0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 32'h900,      0, 0,            0, 0, 0, 32'h100,      32'h100,      1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0, 0, 32'h100,      32'h100,      0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            1, 32'h700,      0, 0, 0, 32'h700,      32'h700,      1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 0, 0,            0, 0, 0, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFE, 0, 0,            0, 0, 0, 32'h0,        32'hFFFFFFFE, 1, 0, 1, 0));
      vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0, 1, 32'h4,        32'h0,        1, 0, 0, 0));

      @(posedge clk);
      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         set_in(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rt, vecs[i].tv, vecs[i].tvec,
                vecs[i].hr, vecs[i].res, vecs[i].cmp);
         tick();
         check_dut($sformatf("vec%0d", i), 0, vecs[i].pc0, vecs[i].v, vecs[i].h, vecs[i].e0);
         check_dut($sformatf("vec%0d", i), 1, vecs[i].pc1, vecs[i].v, vecs[i].h, vecs[i].e1);
      end

      // Mid-run reset with a pending handshake, then first PC after release.
      set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(1, 1, 0, 0, 1, 32'h40, 0, 0, 0);
      tick();
      check_dut("rst_mid", 0, RV, 0, 0, 0);
      check_dut("rst_mid", 1, RV, 0, 0, 0);
      set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      check_dut("rst_rel1", 0, RV, 1, 0, 0);
      check_dut("rst_rel1", 1, RV, 1, 0, 0);
      tick();
      check_dut("rst_rel2", 0, RV + 4, 1, 0, 0);
      check_dut("rst_rel2", 1, RV + 4, 1, 0, 0);

      // Misalign pulse lasts exactly one cycle.
      set_in(0, 0, 1, 32'h3, 0, 0, 0, 0, 0);
      tick();
      check_dut("err_pulse", 0, RV + 4, 1, 0, 1);
      check_dut("err_pulse", 1, RV + 4, 1, 0, 1);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      check_dut("err_clear", 0, RV + 4, 1, 0, 0);
      check_dut("err_clear", 1, RV + 4, 1, 0, 0);

      // Randomized run against the reference model.
      for (int i = 0; i < 800; i++) begin
         logic [31:0] rt, tvv;
         rt  = $urandom;
         tvv = $urandom;
         rt[1:0]  = 2'($urandom_range(0, 3));
         tvv[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         if ($urandom_range(0, 7) == 0) rt = 32'hFFFF_FFF8 | {29'd0, rt[2:0]};
         set_in($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 5) == 0, rt, $urandom_range(0, 9) == 0, tvv,
                $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
         tick();
         check_model($sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
